// File: rtl/pattern_detect_pkg.sv
// Shared FSM encoding, parameter defaults and config-length check for the serial pattern detector.
// No logic of its own; no latency or backpressure.
package pattern_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int LEN_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Serial history shift register, fill counter and length-masked compare against the pattern.
// hit is combinational on the post-shift view; no backpressure, one bit per shift.
module pattern_matcher
    import pattern_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift,
    input  logic               data_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    output logic               hit
);

    localparam int                FILL_W   = $clog2(MAX_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

    // Only MAX_LEN-1 past bits are stored; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_inc;
    logic               fill_ok;
    logic               bits_eq;

    assign hist_nxt = {hist_q, data_in};
    assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
    end

    assign fill_ok = (int'(fill_inc) >= int'(len));
    assign bits_eq = ((hist_nxt & len_mask) == (pattern & len_mask));
    assign hit     = shift && fill_ok && bits_eq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_nxt[MAX_LEN-2:0];
            fill_q <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Serial pattern detector control: config capture, IDLE/ARMED/DONE FSM, match counting and limit.
// match pulses 1 cycle after the accepting edge; cfg_ready drops while ARMED, data is never stalled.
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_limit,
    input  logic               start,
    input  logic               stop,
    input  logic               data_valid,
    input  logic               data_in,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic               cfg_ok;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   lim_q;
    logic [CNT_W-1:0]   count_q;
    logic               match_q;
    logic               cfg_err_q;

    logic               cfg_hs;
    logic               cfg_legal;
    logic               cfg_ok_eff;
    logic               start_go;
    logic               start_ok;
    logic               start_bad;
    logic               shift;
    logic               hit;
    logic [CNT_W-1:0]   count_inc;

    assign cfg_ready  = (state != ST_ARMED);
    assign cfg_hs     = cfg_valid && cfg_ready;
    assign cfg_legal  = len_legal(cfg_len, MAX_LEN);
    assign cfg_ok_eff = cfg_ok || (cfg_hs && cfg_legal);

    // In DONE an abort wins over a re-arm; in IDLE stop is meaningless so start proceeds.
    assign start_go  = start && ((state == ST_IDLE) || ((state == ST_DONE) && !stop));
    assign start_ok  = start_go && cfg_ok_eff;
    assign start_bad = start_go && !cfg_ok_eff;

    assign shift     = (state == ST_ARMED) && data_valid && !stop;
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);

    pattern_matcher #(
        .MAX_LEN (MAX_LEN)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_ok),
        .shift   (shift),
        .data_in (data_in),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cfg_ok    <= 1'b0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            lim_q     <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            cfg_err_q <= (cfg_hs && !cfg_legal) || start_bad;

            if (cfg_hs && cfg_legal) begin
                pat_q  <= cfg_pattern;
                len_q  <= cfg_len;
                ovl_q  <= cfg_overlap;
                lim_q  <= cfg_limit;
                cfg_ok <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state   <= ST_ARMED;
                        count_q <= '0;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (hit) begin
                        match_q <= 1'b1;
                        count_q <= count_inc;
                        if ((lim_q != '0) && (count_inc == lim_q)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (start_ok) begin
                        state   <= ST_ARMED;
                        count_q <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state == ST_ARMED);
    assign done        = (state == ST_DONE);
    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: per-cycle vector table plus hand-driven reset corner case.
module tb_pattern_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [3:0]         cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic [CNT_W-1:0]   cfg_limit = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               data_valid = 1'b0;
    logic               data_in = 1'b0;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               done;
    logic               cfg_err;

    always #5 clk = ~clk;

    pattern_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_limit   (cfg_limit),
        .start       (start),
        .stop        (stop),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    typedef struct packed {
        logic       m;
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       err;
        logic       rdy;
    } outs_t;

    typedef struct packed {
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] lim;
        logic       st;
        logic       sp;
        logic       dv;
        logic       di;
        outs_t      exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic outs_t mk_exp(input int m, input int cnt, input int b, input int d, input int e);
        outs_t o;
        o.m    = 1'(m);
        o.cnt  = 8'(cnt);
        o.busy = 1'(b);
        o.done = 1'(d);
        o.err  = 1'(e);
        o.rdy  = ~1'(b);
        return o;
    endfunction

    task automatic v(input int cv, input int pat, input int len, input int ov, input int lim,
                     input int st, input int sp, input int dv, input int di,
                     input int m, input int cnt, input int b, input int d, input int e);
        vec_t x;
        x.cv  = 1'(cv);
        x.pat = 8'(pat);
        x.len = 4'(len);
        x.ov  = 1'(ov);
        x.lim = 8'(lim);
        x.st  = 1'(st);
        x.sp  = 1'(sp);
        x.dv  = 1'(dv);
        x.di  = 1'(di);
        x.exp = mk_exp(m, cnt, b, d, e);
        vecs.push_back(x);
    endtask

    task automatic cfg(input int pat, input int len, input int ov, input int lim, input int st,
                       input int cnt, input int b, input int e);
        v(1, pat, len, ov, lim, st, 0, 0, 0, 0, cnt, b, 0, e);
    endtask

    task automatic ctl(input int st, input int sp, input int cnt, input int b, input int d, input int e);
        v(0, 0, 0, 0, 0, st, sp, 0, 0, 0, cnt, b, d, e);
    endtask

    task automatic dbit(input int dv, input int di, input int sp,
                        input int m, input int cnt, input int b, input int d);
        v(0, 0, 0, 0, 0, 0, sp, dv, di, m, cnt, b, d, 0);
    endtask

    task automatic check_outs(input string name);
        outs_t got;
        outs_t want;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
            return;
        end
        want     = exp_q.pop_front();
        got.m    = match;
        got.cnt  = match_count;
        got.busy = busy;
        got.done = done;
        got.err  = cfg_err;
        got.rdy  = cfg_ready;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got match=%0b count=%0d busy=%0b done=%0b cfg_err=%0b cfg_ready=%0b, want match=%0b count=%0d busy=%0b done=%0b cfg_err=%0b cfg_ready=%0b",
                     name, got.m, got.cnt, got.busy, got.done, got.err, got.rdy,
                     want.m, want.cnt, want.busy, want.done, want.err, want.rdy);
        end
    endtask

    task automatic apply(input vec_t x, input string name);
        cfg_valid   = x.cv;
        cfg_pattern = x.pat;
        cfg_len     = x.len;
        cfg_overlap = x.ov;
        cfg_limit   = x.lim;
        start       = x.st;
        stop        = x.sp;
        data_valid  = x.dv;
        data_in     = x.di;
        exp_q.push_back(x.exp);
        @(posedge clk);
        #1;
        check_outs(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t x;

        // No legal config yet: bad lengths and a start all raise cfg_err
        cfg(8'hFF, 0, 0, 0, 0, 0, 0, 1);
        ctl(0, 0, 0, 0, 0, 0);
        cfg(8'hFF, 9, 0, 0, 0, 0, 0, 1);
        ctl(0, 0, 0, 0, 0, 0);
        ctl(1, 0, 0, 0, 0, 1);
        ctl(0, 0, 0, 0, 0, 0);
        // 1011 non-overlap, stream 1 _ 0 1 1 0 1 1 with a valid gap
        cfg(8'h0B, 4, 0, 0, 0, 0, 0, 0);
        ctl(1, 0, 0, 1, 0, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(0, 0, 0, 0, 0, 1, 0);
        dbit(1, 0, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 1, 1, 1, 0);
        dbit(1, 0, 0, 0, 1, 1, 0);
        dbit(1, 1, 0, 0, 1, 1, 0);
        dbit(1, 1, 0, 0, 1, 1, 0);
        ctl(0, 0, 1, 1, 0, 0);
        ctl(0, 1, 1, 0, 0, 0);
        ctl(0, 1, 1, 0, 0, 0);
        // Illegal handshake must not disturb the stored 1011 / limit 0 config
        cfg(8'hFF, 9, 1, 1, 0, 1, 0, 1);
        ctl(1, 0, 0, 1, 0, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 0, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 1, 1, 1, 0);
        ctl(0, 1, 1, 0, 0, 0);
        // Overlap mode with config and start on the same cycle
        cfg(8'h0B, 4, 1, 0, 1, 0, 1, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 0, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 1, 1, 1, 0);
        dbit(1, 0, 0, 0, 1, 1, 0);
        dbit(1, 1, 0, 0, 1, 1, 0);
        dbit(1, 1, 0, 1, 2, 1, 0);
        ctl(0, 1, 2, 0, 0, 0);
        // 11 overlap limit 3: DONE after third match, fifth bit ignored
        cfg(8'h03, 2, 1, 3, 0, 2, 0, 0);
        ctl(1, 0, 0, 1, 0, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(1, 1, 0, 1, 1, 1, 0);
        dbit(1, 1, 0, 1, 2, 1, 0);
        dbit(1, 1, 0, 1, 3, 0, 1);
        dbit(1, 1, 0, 0, 3, 0, 1);
        ctl(0, 0, 3, 0, 1, 0);
        ctl(0, 1, 3, 0, 0, 0);
        // 101 with gaps, stop lands on the completing bit
        cfg(8'h05, 3, 0, 0, 1, 0, 1, 0);
        dbit(1, 1, 0, 0, 0, 1, 0);
        dbit(0, 1, 0, 0, 0, 1, 0);
        dbit(1, 0, 0, 0, 0, 1, 0);
        dbit(0, 0, 0, 0, 0, 1, 0);
        dbit(1, 1, 1, 0, 0, 0, 0);
        ctl(0, 0, 0, 0, 0, 0);

        // Reset state
        #3;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0));
        check_outs("reset_async");
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0));
        check_outs("reset_held");
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while ARMED, right before the edge that would complete 1011
        x = '0;
        x.cv = 1'b1; x.pat = 8'h0B; x.len = 4'd4; x.st = 1'b1;
        x.exp = mk_exp(0, 0, 1, 0, 0);
        apply(x, "rst_arm");
        x = '0;
        x.dv = 1'b1; x.di = 1'b1;
        x.exp = mk_exp(0, 0, 1, 0, 0);
        apply(x, "rst_bit1");
        x.di = 1'b0;
        apply(x, "rst_bit2");
        x.di = 1'b1;
        apply(x, "rst_bit3");
        data_valid = 1'b1;
        data_in    = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0));
        check_outs("rst_mid_async");
        @(posedge clk);
        #1;
        exp_q.push_back(mk_exp(0, 0, 0, 0, 0));
        check_outs("rst_mid_edge");
        rst = 1'b1;
        // cfg_ok cleared by reset: start must be refused
        x = '0;
        x.st = 1'b1;
        x.exp = mk_exp(0, 0, 0, 0, 1);
        apply(x, "rst_cfg_cleared");
        x = '0;
        x.exp = mk_exp(0, 0, 0, 0, 0);
        apply(x, "rst_after_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_detect_ctrl.md
PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accepted when high together with cfg_valid.
REQ-008 cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first serial bit, bit [0] the last.
REQ-009 cfg_len  input  4  pattern length; legal range 1..MAX_LEN.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_limit  input  CNT_W  match limit; 0 = unlimited.
REQ-012 start  input  1  arm detection.
REQ-013 stop  input  1  abort detection.
REQ-014 data_valid  input  1  qualifies data_in.
REQ-015 data_in  input  1  serial data bit.
REQ-016 busy  output  1  high in ARMED.
REQ-017 match  output  1  one-cycle match pulse.
REQ-018 match_count  output  CNT_W  matches since last start.
REQ-019 done  output  1  high in DONE.
REQ-020 cfg_err  output  1  one-cycle error pulse.

Function
REQ-021 FSM states SHALL be IDLE, ARMED and DONE.
REQ-022 cfg_ready SHALL be high in IDLE and DONE and low in ARMED.
REQ-023 A configuration handshake SHALL capture the pattern, length, overlap mode and limit; it SHALL set an internal cfg_ok flag.
REQ-024 A handshake with cfg_len 0 or cfg_len > MAX_LEN SHALL leave the stored configuration unchanged and pulse cfg_err for 1 cycle.
REQ-025 start in IDLE/DONE with cfg_ok=1 SHALL enter ARMED next cycle, clear the history fill and clear match_count to 0.
REQ-026 start with cfg_ok=0 SHALL be ignored and SHALL pulse cfg_err for 1 cycle.
REQ-027 On a simultaneous legal handshake and start, the newly captured configuration SHALL be used.
REQ-028 In ARMED, each cycle with data_valid=1 SHALL shift data_in into the history LSB and increment fill, saturating at MAX_LEN; cycles with data_valid=0 SHALL change nothing.
REQ-029 A match SHALL occur when the post-shift fill is >= len and the low len history bits equal cfg_pattern[len-1:0]; match SHALL pulse in the cycle after the accepting edge (1-cycle latency).
REQ-030 In non-overlap mode, fill SHALL be reset to 0 on a match; in overlap mode, fill SHALL be kept.
REQ-031 Each match SHALL increment match_count, saturating at 2^CNT_W-1.
REQ-032 If limit != 0 and match_count reaches limit, the FSM SHALL enter DONE on the same edge; further data SHALL be ignored.
REQ-033 stop in ARMED SHALL enter IDLE next cycle; a bit valid in that cycle SHALL be discarded and SHALL produce no match; stop SHALL take priority over a simultaneous match.
REQ-034 stop in DONE SHALL enter IDLE; stop in IDLE SHALL have no effect.
REQ-035 match_count SHALL hold its value in IDLE and DONE until the next accepted start.

Reset
REQ-036 Asserting rst SHALL immediately force IDLE, clear cfg_ok, the configuration registers, the history and fill, and set match_count to 0.
REQ-037 Outputs during and after reset SHALL be: cfg_ready=1, and busy, match, done and cfg_err all 0.
REQ-038 Reset asserted mid-ARMED SHALL discard any pending match pulse.

Structure
REQ-039 Package pattern_detect_pkg SHALL hold the FSM state encoding and the MAX_LEN/CNT_W defaults.
REQ-040 Sub-module pattern_matcher SHALL hold the history shift register, the fill counter and the length-masked compare; the top level SHALL hold the FSM, configuration and counter.

Verification
REQ-041 Configure 1011, len 4, non-overlap, limit 0; start; stream 1011011 -> exactly 1 match pulse, one cycle after bit 4; match_count=1.
REQ-042 Same configuration with overlap=1 and the same stream -> matches after bits 4 and 7; match_count=2.
REQ-043 Configure 11, len 2, overlap, limit 3; stream 11111 -> 3 matches; done=1 after the 3rd match; busy=0; 5th bit ignored.
REQ-044 Handshake with cfg_len=0, then with cfg_len=9 -> cfg_err pulses twice; start with no prior legal configuration -> cfg_err, FSM stays IDLE.
REQ-045 Stream 101 with data_valid gaps, then stop on the same cycle as the final 1 -> no match; IDLE next cycle; match_count=0.
REQ-046 Assert rst mid-stream in ARMED -> IDLE, cfg_ready=1, match_count=0, no match pulse.
